// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//
// Core-side initiator for the CP0 exception interface. Takes one trap-class
// instruction (syscall, break, teq, eret) from the multicycle core, checks it
// against the CP0 status masks and, when taken, drives a single-cycle
// exception or eret strobe into CP0. It always finishes with a one-cycle
// fetch redirect: exception vector, CP0 return address, or pc+4.
//
// Configuration macro:
//   TRAP_TEQ_EN  defined   -> teq is evaluated (operand compare present)
//                undefined -> kind 3 is handled like an invalid kind
//
// Parameters:
//   VECTOR_ADDR  exception handler entry address
//   COUNT_W      width of the taken-exception counter
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake with the core
//   req_kind          1 syscall, 2 break, 3 teq, 4 eret (others invalid)
//   req_pc            pc of the requesting instruction
//   teq_rs, teq_rt    teq operands
//   status            CP0 status register (used in EVAL only)
//   exc_addr          CP0 return address (used in COMMIT on eret)
//   cp0_exception     exception strobe to CP0
//   cp0_eret          eret strobe to CP0
//   cp0_cause         exception cause code
//   cp0_pc            latched pc, saved by CP0 as EPC
//   redirect_valid    one-cycle fetch redirect
//   redirect_pc       redirect target
//   busy              high outside IDLE
//   trap_count        saturating count of taken exceptions (eret excluded)
// -----------------------------------------------------------------------------
module trap_sequencer #(
  parameter logic [31:0] VECTOR_ADDR = 32'h0040_0004,
  parameter int          COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_kind,
  input  logic [31:0]        req_pc,
  input  logic [31:0]        teq_rs,
  input  logic [31:0]        teq_rt,
  input  logic [31:0]        status,
  input  logic [31:0]        exc_addr,
  output logic               cp0_exception,
  output logic               cp0_eret,
  output logic [4:0]         cp0_cause,
  output logic [31:0]        cp0_pc,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               busy,
  output logic [COUNT_W-1:0] trap_count
);

  localparam logic [2:0] KIND_SYSCALL = 3'd1;
  localparam logic [2:0] KIND_BREAK   = 3'd2;
  localparam logic [2:0] KIND_TEQ     = 3'd3;
  localparam logic [2:0] KIND_ERET    = 3'd4;

  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t       state, state_nx;
  logic [2:0]   kind_q;
  logic [31:0]  pc_q;
  logic [31:0]  target_q;
  logic [4:0]   cause_q;
  logic [COUNT_W-1:0] count_q;
  logic         taken;
  logic [4:0]   exc_cause;
  logic         is_eret;

`ifdef TRAP_TEQ_EN
  logic eq_q;
  // Only the upper status bits are ignored in this build.
  logic unused_status;
  assign unused_status = ^status[31:4];
`else
  // teq operands and the teq mask bit play no part in this build.
  logic unused_teq;
  assign unused_teq = ^{teq_rs, teq_rt, status[31:3]};
`endif

  assign is_eret = (kind_q == KIND_ERET);

  // Taken decision and cause, evaluated against the live status in EVAL.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    taken     = 1'b0;
    exc_cause = 5'b0;
    unique case (kind_q)
      KIND_SYSCALL: begin
        taken     = status[0] & status[1];
        exc_cause = CAUSE_SYSCALL;
      end
      KIND_BREAK: begin
        taken     = status[0] & status[2];
        exc_cause = CAUSE_BREAK;
      end
`ifdef TRAP_TEQ_EN
      KIND_TEQ: begin
        taken     = status[0] & status[3] & eq_q;
        exc_cause = CAUSE_TEQ;
      end
`endif
      KIND_ERET: taken = 1'b1;
      default: ;
    endcase
  end

  // Next state and control outputs.
  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    busy           = 1'b1;
    cp0_exception  = 1'b0;
    cp0_eret       = 1'b0;
    redirect_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = EVAL;
      end
      EVAL:     state_nx = taken ? COMMIT : REDIRECT;
      COMMIT: begin
        // Only taken requests reach COMMIT, so kind is either eret or an
        // exception kind; the strobes are mutually exclusive by construction.
        cp0_eret      = is_eret;
        cp0_exception = ~is_eret;
        state_nx      = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        state_nx       = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q   <= 3'd0;
      pc_q     <= 32'd0;
      target_q <= 32'd0;
      cause_q  <= 5'd0;
      count_q  <= '0;
`ifdef TRAP_TEQ_EN
      eq_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            kind_q <= req_kind;
            pc_q   <= req_pc;
`ifdef TRAP_TEQ_EN
            eq_q   <= (teq_rs == teq_rt);
`endif
          end
        end
        EVAL: begin
          // eret leaves the cause register untouched.
          if (taken && !is_eret) cause_q  <= exc_cause;
          if (!taken)            target_q <= pc_q + 32'd4;
        end
        COMMIT: begin
          if (is_eret) begin
            target_q <= exc_addr;
          end else begin
            target_q <= VECTOR_ADDR;
            if (count_q != '1) count_q <= count_q + COUNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cp0_cause   = cause_q;
  assign cp0_pc      = pc_q;
  assign redirect_pc = target_q;
  assign trap_count  = count_q;

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Core-side initiator for the CP0 exception interface. Accepts one trap-class instruction at a time from the multicycle core (syscall, break, teq, eret) and checks it against the CP0 status masks. For taken traps it drives the single-cycle `exception`/`eret` strobes (with cause and pc) into the coprocessor. It then issues a one-cycle PC redirect to the fetch stage: the exception vector, the CP0-supplied return address, or pc+4.

## Interface
Parameters:
- `VECTOR_ADDR`, default 32'h0040_0004: exception handler entry address.
- `COUNT_W`, default 16: width of the taken-exception counter.

Ports:
- `clk` in 1: the single clock; all state is updated on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: core presents a trap-class request.
- `req_ready` out 1: sequencer can accept a request.
- `req_kind` in 3: 1 syscall, 2 break, 3 teq, 4 eret; 0 and 5-7 are invalid.
- `req_pc` in 32: pc of the requesting instruction.
- `teq_rs`, `teq_rt` in 32 each: teq operands.
- `status` in 32: CP0 status register.
- `exc_addr` in 32: CP0 return address, valid while `cp0_eret` is high.
- `cp0_exception` out 1: exception strobe to CP0.
- `cp0_eret` out 1: eret strobe to CP0.
- `cp0_cause` out 5: exception cause code.
- `cp0_pc` out 32: pc to be saved as EPC.
- `redirect_valid` out 1: one-cycle fetch redirect.
- `redirect_pc` out 32: redirect target.
- `busy` out 1: high in any state except IDLE.
- `trap_count` out COUNT_W: number of taken exceptions; eret is not counted.

## Operation
States: IDLE, EVAL, COMMIT, REDIRECT.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch kind and pc, and register `eq` = (`teq_rs`==`teq_rt`); go to EVAL.
- **EVAL**
  - Samples `status`; `en` = status[0].
  - Taken conditions:
    - syscall: `en` & status[1]
    - break: `en` & status[2]
    - teq: `en` & status[3] & `eq`
    - eret: always taken
  - Taken: load `cp0_cause` with the cause (syscall 5'b01000, break 5'b01001, teq 5'b01101; eret leaves cause unchanged); go to COMMIT.
  - Not taken or invalid kind: target = latched pc + 4 (mod 2^32); go to REDIRECT.
- **COMMIT** (exactly one cycle)
  - Exception kinds: `cp0_exception`=1; target = `VECTOR_ADDR`; `trap_count` += 1, saturating at all-ones.
  - Eret: `cp0_eret`=1; target = `exc_addr` sampled this cycle.
  - Next state: REDIRECT.
- **REDIRECT**
  - `redirect_valid`=1 and `redirect_pc`=target; go to IDLE.
- `cp0_pc` always shows the latched pc.
- `cp0_exception` and `cp0_eret` are never both high, and each is only ever high in COMMIT.

## Timing
- Request accepted at edge N (IDLE & `req_valid`).
- Taken request:
  - N+1 to N+2: EVAL.
  - N+2 to N+3: COMMIT; strobe high for 1 cycle.
  - N+3 to N+4: REDIRECT; `redirect_valid` high.
- Not-taken request: `redirect_valid` high from N+2 to N+3.
- `req_ready` is low from N+1 until the cycle after REDIRECT.
  - Back-to-back requests are therefore at least 3 (not taken) or 4 (taken) cycles apart.
  - `req_valid` while busy is ignored and not queued; the core holds it.
- Only the value of `status` in EVAL matters. `exc_addr` is sampled only in COMMIT, at the same edge CP0 updates its status on eret.
- Reset values:
  - state IDLE; `req_ready`=1.
  - all strobes, `busy` and `redirect_valid` = 0.
  - `cp0_cause`=0, `cp0_pc`=0, `redirect_pc`=0, `trap_count`=0.
- Reset asserted mid-operation: immediate return to IDLE, no strobe or redirect issued, `trap_count` cleared.

## Configuration
- `TRAP_TEQ_EN` defined: teq is evaluated as above; the `eq` compare is present.
- `TRAP_TEQ_EN` undefined: kind 3 is treated as invalid (not taken, redirect to pc+4), and `teq_rs`/`teq_rt` are unused.

## Test plan
- Syscall, `req_pc`=0x0040_0100, `status`=0xF:
  - `cp0_exception` pulses 1 cycle with `cp0_cause`=01000 and `cp0_pc`=0x0040_0100.
  - Then `redirect_pc`=0x0040_0004 and `trap_count`=1.
- Break with `status`=0xB (break masked): no strobe; `redirect_pc`=pc+4; `trap_count` unchanged.
- Teq with rs=rt=7 and `status`=0xF:
  - `cause`=01101.
  - rs=7, rt=8: not taken, redirect pc+4.
  - With `TRAP_TEQ_EN` undefined: not taken in both cases.
- Eret with `exc_addr`=0x0040_0200: `cp0_eret` pulses 1 cycle; `redirect_pc`=0x0040_0200; `trap_count` unchanged.
- Edge cases:
  - `req_pc`=0xFFFF_FFFC not taken: redirect to 0x0000_0000.
  - `rst` pulsed during COMMIT: no redirect, outputs at reset values.
  - `req_valid` held across busy: exactly one accept per IDLE visit.
